traffic_light_monitor: RTL
==========================

Name: traffic_light_monitor

Overview:
Passive checker on the light outputs {green, red, yellow} of the intersection controller. It tracks the observed phase and how long it has lasted, and flags three kinds of fault: a light vector that is not one-hot, a phase transition out of order, and a phase of the wrong length. It also counts complete fault-free yellow->red->green loops. It sits beside the controller in the top level and in testbenches, and never drives the lights.

Parameters:
CNT_W, 8, width of the phase-duration counter; every *_LEN must be ≤ 2^CNT_W-1
YELLOW_LEN, 4, required yellow phase length in clk cycles
RED_LEN, 31, required red phase length in clk cycles
GREEN_LEN, 28, required green phase length in clk cycles
LOOP_W, 16, width of the loop counter

Ports:
clk  in  1  clock, all logic on rising edge
rstn  in  1  asynchronous active-low reset
green  in  1  observed green light
red  in  1  observed red light
yellow  in  1  observed yellow light
clr  in  1  synchronous clear of err_sticky and loop_cnt
phase  out  2  current phase: 0 NONE, 1 YELLOW, 2 RED, 3 GREEN
phase_cnt  out  CNT_W  consecutive samples of the current phase, saturating at all-ones
err_onehot  out  1  1-cycle pulse: light vector was not one-hot
err_order  out  1  1-cycle pulse: illegal phase transition
err_len  out  1  1-cycle pulse: phase was too short or overran
err_sticky  out  1  OR of all errors since reset or clr
loop_cnt  out  LOOP_W  clean loops completed, saturating

Behaviour:
- Reset (asynchronous, any time, including mid-phase): phase=NONE; phase_cnt=0; all err_* =0; loop_cnt=0; internal ovr=0, clean=0.
- The light inputs are sampled on every rising clk edge. All outputs are registered and reflect the sample taken at that edge (one-cycle latency).
- Legal order: YELLOW->RED->GREEN->YELLOW. expected(P) = that phase's *_LEN.
- Sample not one-hot (000, 011, 110, 101, 111):
  - err_onehot=1.
  - phase->NONE, phase_cnt->0, ovr->0, clean->0.
  - No order or length check on this sample.
- One-hot sample P with P == phase:
  - phase_cnt+1 (saturating).
  - If the new count equals expected(P)+1 and ovr=0: err_len=1, ovr->1, clean->0. The overrun is reported only once per phase.
- One-hot sample P with P != phase, phase == NONE (start or resync):
  - phase->P, phase_cnt->1, ovr->0, no checks.
  - clean->1 if P==YELLOW, else 0.
- One-hot sample P with P != phase, phase != NONE:
  - If P != next(phase): err_order=1, clean->0.
  - If phase_cnt != expected(phase) and ovr=0: err_len=1, clean->0 (short phase).
  - If phase==GREEN, P==YELLOW, no error on this sample and clean=1: loop_cnt+1 (saturating at all-ones).
  - Then phase->P, phase_cnt->1, ovr->0. clean->1 if P==YELLOW, else keeps its value after the checks above.
- err_order and err_len may both pulse on the same edge.
- err_sticky is set by any err_* pulse.
- clr=1: err_sticky->0 and loop_cnt->0, except:
  - an error on the same edge wins: err_sticky=1.
  - a loop completion on the same edge wins: loop_cnt=1.
- Width rule: phase_cnt compares are CNT_W bits wide; a saturated count still counts as overrun.

Test Plan:
1. Drive the monitor from the real controller after a common reset for 700 cycles -> no err_* pulses, err_sticky=0. After edge 4: phase=YELLOW, phase_cnt=4. After edge 5: phase=RED, phase_cnt=1. loop_cnt=1 after edge 64, loop_cnt=n after edge 63n+1, loop_cnt=11 at cycle 700.
2. Drive Y×4, R×30, then G -> err_len pulse exactly at the first G sample, err_order=0, err_sticky=1; the following G×28 -> Y transition leaves loop_cnt unchanged.
3. Drive Y×4, R×31, G×35 -> a single err_len pulse at the 29th G sample, none at the later G->Y transition, phase_cnt=35 before Y.
4. Drive Y×4 then G -> err_order pulse only, phase=GREEN, phase_cnt=1. Drive Y×3 then G -> err_order and err_len on the same edge.
5. Mid-red, drive 3'b000 for one cycle, then red again -> err_onehot pulse, phase=NONE, phase_cnt=0, then phase=RED, phase_cnt=1 with no order error. Repeat with 3'b110 -> same.
6. Assert clr on the same edge as an err_len -> err_sticky stays 1. Assert clr on a quiet edge -> err_sticky=0, loop_cnt=0. Drop rstn mid-green -> all outputs 0 immediately, without waiting for a clk edge.

Source files
------------

// File: rtl/traffic_light_monitor.sv
// Passive checker for the intersection light outputs.
// Tracks phase and duration, flags faults and counts clean loops.
module traffic_light_monitor #(
  parameter int CNT_W      = 8,
  parameter int YELLOW_LEN = 4,
  parameter int RED_LEN    = 31,
  parameter int GREEN_LEN  = 28,
  parameter int LOOP_W     = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              green,
  input  logic              red,
  input  logic              yellow,
  input  logic              clr,
  output logic [1:0]        phase,
  output logic [CNT_W-1:0]  phase_cnt,
  output logic              err_onehot,
  output logic              err_order,
  output logic              err_len,
  output logic              err_sticky,
  output logic [LOOP_W-1:0] loop_cnt
);

  typedef enum logic [1:0] {
    PH_NONE   = 2'd0,
    PH_YELLOW = 2'd1,
    PH_RED    = 2'd2,
    PH_GREEN  = 2'd3
  } phase_e;

  phase_e             r_phase;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovr;
  logic               r_clean;
  logic               r_e_oh;
  logic               r_e_ord;
  logic               r_e_len;
  logic               r_sticky;
  logic [LOOP_W-1:0]  r_loop;

  phase_e             w_p;
  logic               w_onehot;
  phase_e             w_phase;
  logic [CNT_W-1:0]   w_cnt;
  logic               w_ovr;
  logic               w_clean;
  logic               w_e_oh;
  logic               w_e_ord;
  logic               w_e_len;
  logic               w_loop_inc;
  logic               w_err;
  logic [CNT_W-1:0]   w_exp_cur;
  logic [CNT_W-1:0]   w_cnt_inc;

  function automatic logic [CNT_W-1:0] exp_len(phase_e p);
    logic [CNT_W-1:0] v;
    v = '0;
    unique case (p)
      PH_YELLOW: v = CNT_W'(YELLOW_LEN);
      PH_RED:    v = CNT_W'(RED_LEN);
      PH_GREEN:  v = CNT_W'(GREEN_LEN);
      default:   v = '0;
    endcase
    return v;
  endfunction

  function automatic phase_e next_ph(phase_e p);
    phase_e v;
    v = PH_NONE;
    unique case (p)
      PH_YELLOW: v = PH_RED;
      PH_RED:    v = PH_GREEN;
      PH_GREEN:  v = PH_YELLOW;
      default:   v = PH_NONE;
    endcase
    return v;
  endfunction

  // Decode the sampled light vector; w_p only meaningful when one-hot.
  always_comb begin
    w_onehot = ({1'b0, green} + {1'b0, red} + {1'b0, yellow}) == 2'd1;
    if (yellow)   w_p = PH_YELLOW;
    else if (red) w_p = PH_RED;
    else          w_p = PH_GREEN;
  end

  assign w_exp_cur = exp_len(r_phase);
  assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;

  // Next-state and fault detection for the current sample.
  always_comb begin
    w_phase    = r_phase;
    w_cnt      = r_cnt;
    w_ovr      = r_ovr;
    w_clean    = r_clean;
    w_e_oh     = 1'b0;
    w_e_ord    = 1'b0;
    w_e_len    = 1'b0;
    w_loop_inc = 1'b0;
    if (!w_onehot) begin
      w_e_oh  = 1'b1;
      w_phase = PH_NONE;
      w_cnt   = '0;
      w_ovr   = 1'b0;
      w_clean = 1'b0;
    end else if (w_p == r_phase) begin
      w_cnt = w_cnt_inc;
      // Old count already at the limit means this sample overruns,
      // which also covers a count stuck at saturation.
      if (r_cnt >= w_exp_cur && !r_ovr) begin
        w_e_len = 1'b1;
        w_ovr   = 1'b1;
        w_clean = 1'b0;
      end
    end else if (r_phase == PH_NONE) begin
      w_phase = w_p;
      w_cnt   = CNT_W'(1);
      w_ovr   = 1'b0;
      w_clean = (w_p == PH_YELLOW);
    end else begin
      if (w_p != next_ph(r_phase)) begin
        w_e_ord = 1'b1;
        w_clean = 1'b0;
      end
      if (r_cnt != w_exp_cur && !r_ovr) begin
        w_e_len = 1'b1;
        w_clean = 1'b0;
      end
      if (r_phase == PH_GREEN && w_p == PH_YELLOW &&
          !w_e_ord && !w_e_len && r_clean)
        w_loop_inc = 1'b1;
      w_phase = w_p;
      w_cnt   = CNT_W'(1);
      w_ovr   = 1'b0;
      if (w_p == PH_YELLOW) w_clean = 1'b1;
    end
    w_err = w_e_oh | w_e_ord | w_e_len;
  end

  // Phase tracking state and error pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_phase <= PH_NONE;
      r_cnt   <= '0;
      r_ovr   <= 1'b0;
      r_clean <= 1'b0;
      r_e_oh  <= 1'b0;
      r_e_ord <= 1'b0;
      r_e_len <= 1'b0;
    end else begin
      r_phase <= w_phase;
      r_cnt   <= w_cnt;
      r_ovr   <= w_ovr;
      r_clean <= w_clean;
      r_e_oh  <= w_e_oh;
      r_e_ord <= w_e_ord;
      r_e_len <= w_e_len;
    end
  end

  // Sticky error and loop counter; same-edge events beat clr.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sticky <= 1'b0;
      r_loop   <= '0;
    end else begin
      if (w_err)    r_sticky <= 1'b1;
      else if (clr) r_sticky <= 1'b0;
      if (w_loop_inc) begin
        if (clr)                r_loop <= LOOP_W'(1);
        else if (r_loop != '1)  r_loop <= r_loop + 1'b1;
      end else if (clr) begin
        r_loop <= '0;
      end
    end
  end

  assign phase      = r_phase;
  assign phase_cnt  = r_cnt;
  assign err_onehot = r_e_oh;
  assign err_order  = r_e_ord;
  assign err_len    = r_e_len;
  assign err_sticky = r_sticky;
  assign loop_cnt   = r_loop;

endmodule
